// File: rtl/alu_pkg.sv
// Shared types for the struct/union ALU and the logic that issues work to it.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum bit [2:0] {add, sub, mul, div, sl, sr} opcode_t;
  typedef enum bit {sign, unsign} operand_type_t;

  typedef union packed {
    logic [ALU_W-1:0]      u_data;
    bit signed [ALU_W-1:0] s_data;
  } data_t;

  typedef struct packed {
    opcode_t       opr;
    operand_type_t opr_type;
    data_t         opr_a;
    data_t         opr_b;
  } instr_t;

  localparam opcode_t OP_LAST = sr;

  typedef enum logic [1:0] {IDLE, HOLD, RESP} issue_state_t;

  // Divide by zero and the two unassigned opcodes are flagged to the consumer.
  function automatic logic instr_err(input instr_t i);
    return ((i.opr == div) && (i.opr_b.u_data == '0)) || (i.opr > OP_LAST);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant,
// hold the instruction ALU_LAT cycles, return the tagged result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  instr_t [NUM_REQ-1:0]        req_instr,
  output instr_t                      alu_instr,
  input  data_t                       alu_result,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output data_t                       resp_data,
  output logic [ID_W-1:0]             resp_id,
  output logic                        resp_err,
  output logic                        busy
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  issue_state_t        state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     id;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     idx;
  logic                any;
  logic [ID_W-1:0]     ptr_next;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  // The handshake completes in IDLE itself, so ready is combinational.
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign ptr_next  = (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      id         <= '0;
      cnt        <= '0;
      alu_instr  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            alu_instr <= req_instr[idx];
            id        <= idx;
            cnt       <= CNT_W'(ALU_LAT - 1);
            busy      <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            resp_data  <= alu_result;
            resp_id    <= id;
            resp_err   <= instr_err(alu_instr);
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            ptr        <= ptr_next;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed and random checks of alu_issue_ctrl against a behavioural ALU and
// round-robin model; a second instance covers the longer ALU latency and reset.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk;
  int   checks;
  int   failures;
  int   ptr_m;

  // instance 0: ALU_LAT=1
  logic         rst;
  logic [3:0]   req_valid, req_ready;
  instr_t [3:0] req_instr;
  instr_t       alu_instr;
  data_t        alu_result, resp_data;
  logic         resp_valid, resp_ready, resp_err, busy;
  logic [1:0]   resp_id;

  // instance 1: ALU_LAT=3
  logic         rst1;
  logic [3:0]   req_valid1, req_ready1;
  instr_t [3:0] req_instr1;
  instr_t       alu_instr1;
  data_t        alu_result1, resp_data1;
  logic         resp_valid1, resp_ready1, resp_err1, busy1;
  logic [1:0]   resp_id1;

  function automatic logic [31:0] alu_ref(input instr_t i);
    logic [31:0] a, b;
    a = i.opr_a.u_data;
    b = i.opr_b.u_data;
    case (i.opr)
      add: return a + b;
      sub: return a - b;
      mul: return a * b;
      div: begin
        if (b == 0) return '0;
        else if (i.opr_type == sign) return 32'($signed(a) / $signed(b));
        else return a / b;
      end
      sl: return a << b[4:0];
      sr: return (i.opr_type == sign) ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      default: return '0;
    endcase
  endfunction

  function automatic logic err_ref(input instr_t i);
    return (i.opr == div && i.opr_b.u_data == 0) || (int'(i.opr) > 5);
  endfunction

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  function automatic instr_t mk(input opcode_t o, input operand_type_t t,
                                input logic [31:0] a, input logic [31:0] b);
    instr_t r;
    r.opr = o;
    r.opr_type = t;
    r.opr_a.u_data = a;
    r.opr_b.u_data = b;
    return r;
  endfunction

  assign alu_result.u_data  = alu_ref(alu_instr);
  assign alu_result1.u_data = alu_ref(alu_instr1);

  alu_issue_ctrl #(.NUM_REQ(4), .ALU_LAT(LAT0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .alu_instr(alu_instr), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_err(resp_err), .busy(busy)
  );

  alu_issue_ctrl #(.NUM_REQ(4), .ALU_LAT(LAT1)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_instr(req_instr1), .alu_instr(alu_instr1), .alu_result(alu_result1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_data(resp_data1),
    .resp_id(resp_id1), .resp_err(resp_err1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge with instance 0 idle and inputs set up.
  task automatic txn(input int bp, output int gid, output logic [31:0] d, output logic e);
    instr_t ins;
    int     g;
    int     lat;
    resp_ready = (bp == 0);
    #1;
    g = pick(req_valid, ptr_m);
    ins = req_instr[g];
    chk("grant", 64'(req_ready), 64'(1 << g));
    chk("busy_idle", 64'(busy), 64'(0));
    @(negedge clk);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      chk("ready_hold", 64'(req_ready), 64'(0));
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(LAT0 + 1));
    gid = int'(resp_id);
    d   = resp_data.u_data;
    e   = resp_err;
    chk("resp_id", 64'(resp_id), 64'(g));
    chk("resp_data", 64'(resp_data.u_data), 64'(alu_ref(ins)));
    chk("resp_err", 64'(resp_err), 64'(err_ref(ins)));
    chk("busy_resp", 64'(busy), 64'(1));
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid), 64'(1));
      chk("bp_data", 64'(resp_data.u_data), 64'(alu_ref(ins)));
      chk("bp_id", 64'(resp_id), 64'(g));
      chk("bp_ready", 64'(req_ready), 64'(0));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("hs_valid", 64'(resp_valid), 64'(0));
    chk("hs_busy", 64'(busy), 64'(0));
    ptr_m = (g + 1) % 4;
  endtask

  initial begin
    int          gid, lat;
    logic [31:0] d;
    logic        e;
    checks = 0; failures = 0; ptr_m = 0;
    rst = 1'b1; rst1 = 1'b1;
    req_valid = '0; req_instr = '0; resp_ready = 1'b1;
    req_valid1 = '0; req_instr1 = '0; resp_ready1 = 1'b1;
    #2;
    chk("rst_valid", 64'(resp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_instr", 64'(alu_instr == '0), 64'(1));
    chk("rst_data", 64'(resp_data.u_data), 64'(0));
    @(negedge clk);
    rst = 1'b0; rst1 = 1'b0;

    // single add
    req_instr[0] = mk(add, sign, 32'h10, 32'h20);
    req_valid = 4'b0001;
    txn(0, gid, d, e);
    chk("t1_data", 64'(d), 64'h30);
    chk("t1_err", 64'(e), 64'(0));
    req_valid = '0;

    // fairness from a fresh pointer
    rst = 1'b1;
    #1;
    chk("rst2_data", 64'(resp_data.u_data), 64'(0));
    @(negedge clk);
    rst = 1'b0; ptr_m = 0;
    for (int i = 0; i < 4; i++) req_instr[i] = mk(sub, sign, 32'(100 + i), 32'd1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      txn(0, gid, d, e);
      chk("rr_id", 64'(gid), 64'(k % 4));
      chk("rr_data", 64'(d), 64'(99 + (k % 4)));
    end

    // backpressure with all requesters valid; pointer sits at 1
    req_instr[1] = mk(mul, unsign, 32'd7, 32'd6);
    txn(10, gid, d, e);
    chk("bp_id1", 64'(gid), 64'(1));
    chk("bp_42", 64'(d), 64'(42));
    txn(0, gid, d, e);
    chk("bp_next", 64'(gid), 64'(2));

    // error cases through requester 0 only
    req_valid = 4'b0001;
    req_instr[0] = mk(div, unsign, 32'h40, 32'h0);
    txn(0, gid, d, e);
    chk("err_div0", 64'(e), 64'(1));
    req_instr[0] = mk(opcode_t'(3'd6), sign, 32'h40, 32'h3);
    txn(0, gid, d, e);
    chk("err_op6", 64'(e), 64'(1));
    req_instr[0] = mk(div, unsign, 32'h40, 32'h4);
    txn(0, gid, d, e);
    chk("div_ok_err", 64'(e), 64'(0));
    chk("div_ok_data", 64'(d), 64'h10);

    // pointer wrap after serving 3
    req_valid = 4'b1000;
    txn(0, gid, d, e);
    chk("wrap_id3", 64'(gid), 64'(3));
    req_valid = 4'b1010;
    txn(0, gid, d, e);
    chk("wrap_id1", 64'(gid), 64'(1));

    // random traffic, masks change between grants
    for (int n = 0; n < 40; n++) begin
      req_valid = 4'($urandom_range(1, 15));
      for (int r = 0; r < 4; r++)
        req_instr[r] = mk(opcode_t'(3'($urandom_range(0, 7))),
                          operand_type_t'(1'($urandom_range(0, 1))),
                          $urandom,
                          ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40)));
      txn(int'($urandom_range(0, 3)), gid, d, e);
    end
    req_valid = '0;

    // ALU_LAT=3 latency
    req_instr1[0] = mk(sl, unsign, 32'd1, 32'd4);
    req_valid1 = 4'b0001;
    #1;
    chk("l3_ready", 64'(req_ready1), 64'(1));
    @(negedge clk);
    lat = 1;
    while (!resp_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("l3_latency", 64'(lat), 64'(LAT1 + 1));
    chk("l3_data", 64'(resp_data1.u_data), 64'h10);
    req_valid1 = '0;
    @(negedge clk);
    chk("l3_done", 64'(busy1), 64'(0));

    // reset during HOLD
    req_valid1 = 4'b0001;
    #1;
    chk("l3_ready2", 64'(req_ready1), 64'(1));
    @(negedge clk);
    chk("l3_busy_hold", 64'(busy1), 64'(1));
    rst1 = 1'b1;
    req_valid1 = 4'b0011;
    #1;
    chk("ar_instr", 64'(alu_instr1 == '0), 64'(1));
    chk("ar_busy", 64'(busy1), 64'(0));
    chk("ar_valid", 64'(resp_valid1), 64'(0));
    chk("ar_data", 64'(resp_data1.u_data), 64'(0));
    chk("ar_id", 64'(resp_id1), 64'(0));
    chk("ar_err", 64'(resp_err1), 64'(0));
    chk("ar_ready", 64'(req_ready1), 64'(0));
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    chk("ar_first", 64'(req_ready1), 64'(1));
    @(negedge clk);
    req_valid1 = '0;
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Shares the single combinational struct/union ALU between NUM_REQ requesters.
- Round-robin arbitration over a valid/ready handshake; the granted instruction word is registered and held stable on the ALU input for ALU_LAT cycles.
- The result is then captured and returned on a single response channel tagged with the requester ID.
- Sits between the instruction sources and the ALU instance; the ALU itself is instantiated outside this block.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ALU_LAT, 1: cycles the ALU input is held before the result is sampled (1..4).
- ID_W, $clog2(NUM_REQ): width of the requester ID.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester instruction valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_instr  in  NUM_REQ x instr_t  per-requester instruction word: opr, opr_type, opr_a, opr_b.
- alu_instr  out  instr_t  registered instruction driven to the ALU.
- alu_result  in  data_t (32)  ALU result, combinational from alu_instr.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer accept.
- resp_data  out  data_t (32)  captured result.
- resp_id  out  ID_W  index of the requester served.
- resp_err  out  1  set for div with opr_b==0, or opcode 6/7.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, alu_instr='0, resp_valid=0, resp_data=0, resp_id=0, resp_err=0, req_ready=0, busy=0, rr pointer=0.
- FSM states: IDLE, HOLD, RESP.
- IDLE:
  - If any req_valid is high, the rr_arbiter picks the first requester at or after the rr pointer (wrapping).
  - req_ready[g] is asserted combinationally in that same cycle; the handshake completes there.
  - alu_instr<=req_instr[g], id<=g, hold counter<=ALU_LAT-1, next state HOLD.
  - With no req_valid, remain in IDLE.
- HOLD:
  - alu_instr is stable; the counter decrements each cycle.
  - On the cycle the counter==0: resp_data<=alu_result, resp_id<=id, resp_err<=error condition, resp_valid<=1, next state RESP.
  - Minimum latency from accept to resp_valid: ALU_LAT+1 clocks.
- RESP:
  - resp_valid, resp_data, resp_id and resp_err are held stable until resp_ready.
  - On resp_valid&&resp_ready: resp_valid<=0, rr pointer<=id+1 (wrapping mod NUM_REQ), next state IDLE.
  - No new grant in the same cycle; one instruction is outstanding at most.
- Error condition:
  - (opr==div && opr_b==0) || opr>sr.
  - resp_data is still the captured ALU value; the consumer ignores it when resp_err=1.
- req_ready is 0 in HOLD and RESP. A requester that holds req_valid is served within NUM_REQ grants (no starvation).
- Simultaneous requests: the lowest index at or after the pointer wins. With pointer=2 and NUM_REQ=4, the search order is 2,3,0,1.
- Requests dropping req_valid before a grant are legal and are simply skipped.
- rst asserted mid-operation: everything returns immediately to reset values and any in-flight instruction is discarded.
- resp_ready held high continuously: back-to-back throughput is one instruction per ALU_LAT+2 cycles.

Decomposition:
- Shared package alu_pkg holds:
  - opcode_t: bit[2:0] {add,sub,mul,div,sl,sr}.
  - operand_type_t: bit {sign,unsign}.
  - data_t: packed union, 32-bit logic u_data and bit signed s_data.
  - instr_t: packed struct {opr, opr_type, opr_a, opr_b}.
  - Constants: ALU_W=32, OP_LAST=sr.
- The ALU module is updated to import alu_pkg.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational.

Test Plan:
1. Single add: requester 0 sends add, sign, a=0x10, b=0x20, with ALU_LAT=1 and resp_ready=1 → req_ready[0] is high in cycle 0; resp_valid rises 2 clocks later with resp_data=0x30, resp_id=0, resp_err=0; busy returns to 0 the cycle after.
2. Round-robin fairness: all 4 requesters hold valid with sub instructions a=100+i, b=1 → resp_id sequence 0,1,2,3,0 and resp_data=99+i each time; no requester is granted twice before all have been served.
3. Backpressure: mul a=7, b=6, resp_ready held low for 10 cycles → resp_valid, resp_data=42 and resp_id stay stable for the whole period; req_ready stays 0 even with other requesters valid; the next grant comes only after the resp_ready handshake.
4. Errors:
   - div a=0x40, b=0 → resp_err=1.
   - opcode 3'd6 → resp_err=1.
   - div a=0x40, b=4 → resp_err=0, resp_data=0x10.
5. Latency and reset:
   - ALU_LAT=3, sl a=1, b=4 → resp_valid exactly 4 clocks after accept, resp_data=0x10.
   - Repeat, asserting rst asynchronously during HOLD → all outputs return to 0 immediately; after release the rr pointer is 0 and requester 0 is granted first.
6. Pointer wrap: NUM_REQ=4, last served id=3, requesters 1 and 3 valid → requester 1 is granted next.
